// File: rtl/pc_sequencer.sv
// Program-counter stage of the single-cycle CPU, directly upstream of the
// instruction memory. Holds the fetch PC, selects the next PC (sequential,
// branch, jump, jump-register) and sequences IDLE/RUN/HALT/FAULT run control.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        pc_write,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] reg_target,
    input  logic        halt_req,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        halted,
    output logic        fault,
    output logic [31:0] retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    // Highest word-aligned address that still lies inside instruction memory.
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    logic [1:0]         state;
    logic [31:0]        next_pc;
    logic signed [31:0] branch_off;

    // A fetch is illegal when misaligned or past the last word of memory.
    function automatic logic illegal_fetch(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_PC);
    endfunction

    assign pc_plus4   = pc + 32'd4;
    // Word offset sign-extended and scaled to bytes.
    assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

    assign running = (state == S_RUN);
    assign halted  = (state == S_HALT);
    assign fault   = (state == S_FAULT);

    // Next-PC selection; all additions wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            SRC_SEQ:    next_pc = pc_plus4;
            SRC_BRANCH: next_pc = branch_taken ? (pc_plus4 + $unsigned(branch_off)) : pc_plus4;
            SRC_JUMP:   next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            default:    next_pc = reg_target;
        endcase
    end

    // Run-control FSM with PC and retired-instruction counter updates.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    pc      <= RESET_PC;
                    retired <= '0;
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Halt takes priority over a faulting or legal advance.
                    if (halt_req) begin
                        state <= S_HALT;
                    end else if (pc_write) begin
                        if (illegal_fetch(next_pc)) begin
                            state <= S_FAULT;
                        end else begin
                            pc      <= next_pc;
                            retired <= retired + 32'd1;
                        end
                    end
                end
                S_HALT, S_FAULT: begin
                    if (start) begin
                        state   <= S_RUN;
                        pc      <= RESET_PC;
                        retired <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
